// File: rtl/pin_synch_filter_pkg.sv
// Shared constants and helpers for the pin synchronizer/filter.
// Counter sizing and legal synchronizer depth live here.
package pin_synch_filter_pkg;

  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;
  localparam int FILTER_MAX = 65535;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 17; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Filter counter never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/pin_synch_filter_chan.sv
// One channel: flop synchronizer, debounce filter, edge pulses.
// Every output comes straight from a flop.
module pin_filter_chan
  import pin_synch_filter_pkg::*;
#(
  parameter int   STAGES        = 2,
  parameter int   FILTER_CYCLES = 1,
  parameter logic RST_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic a,
  output logic y,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(FILTER_CYCLES - 1);

  logic [STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              y_q, y_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              s;

  assign s = sync_q[STAGES-1];

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], a};
    cnt_d  = '0;
    y_d    = y_q;
    // A differing level only wins after a full run.
    if (s != y_q) begin
      if (cnt_q == CNT_LAST) y_d = s;
      else cnt_d = cnt_q + 1'b1;
    end
    rise_d = y_d & ~y_q;
    fall_d = ~y_d & y_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= {STAGES{RST_VAL}};
      cnt_q  <= '0;
      y_q    <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      y_q    <= y_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign y    = y_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/pin_synch_filter.sv
// Multi-channel pin synchronizer with debounce and edge pulses.
// Channels are independent; reset level is per channel.
module pin_synch_filter
  import pin_synch_filter_pkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter int               STAGES        = 2,
  parameter int               FILTER_CYCLES = 1,
  parameter logic [WIDTH-1:0] RST_VAL       = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX)
  begin : g_bad_stages
    $error("pin_synch_filter: STAGES out of range");
  end

  if (FILTER_CYCLES < 1 || FILTER_CYCLES > FILTER_MAX)
  begin : g_bad_filter
    $error("pin_synch_filter: FILTER_CYCLES out of range");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    pin_filter_chan #(
      .STAGES        (STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .RST_VAL       (RST_VAL[i])
    ) u_chan (
      .clk  (clk),
      .rstn (rstn),
      .a    (A[i]),
      .y    (Y[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

endmodule

// File: tb/tb_pin_synch_filter.sv
// Bench: default instance plus a 4-channel filtered instance,
// both checked every cycle against a sliding-window model.
module tb_pin_synch_filter;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] a_in;
  logic [0:0] y0, r0, f0;
  logic [3:0] y1, r1, f1;
  bit         started = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  pin_synch_filter u_d0 (
    .clk  (clk),
    .rstn (rstn),
    .A    (a_in[0:0]),
    .Y    (y0),
    .rise (r0),
    .fall (f0)
  );

  pin_synch_filter #(
    .WIDTH         (4),
    .STAGES        (3),
    .FILTER_CYCLES (3),
    .RST_VAL       (4'b1010)
  ) u_d1 (
    .clk  (clk),
    .rstn (rstn),
    .A    (a_in),
    .Y    (y1),
    .rise (r1),
    .fall (f1)
  );

  // Model configuration per instance.
  int         st [2] = '{2, 3};
  int         fc [2] = '{1, 3};
  logic [3:0] rv [2] = '{4'b0000, 4'b1010};
  logic [3:0] mk [2] = '{4'b0001, 4'b1111};

  // Pin history (oldest first) and window of synced values.
  logic [3:0] hist [2][4];
  logic [3:0] win  [2][8];
  int         wn   [2];
  logic [3:0] ye [2], re [2], fe [2];

  task automatic model_reset(input int d);
    for (int j = 0; j < 4; j++) hist[d][j] = rv[d];
    for (int j = 0; j < 8; j++) win[d][j] = rv[d];
    wn[d] = 0;
    ye[d] = rv[d];
    re[d] = '0;
    fe[d] = '0;
  endtask

  task automatic model_step(input int d);
    logic [3:0] s, ny;
    bit         diff;
    s = hist[d][0];
    for (int j = 0; j < 3; j++)
      if (j < st[d] - 1) hist[d][j] = hist[d][j+1];
    hist[d][st[d]-1] = a_in & mk[d];
    if (wn[d] < fc[d]) begin
      win[d][wn[d]] = s;
      wn[d]++;
    end else begin
      for (int j = 0; j < 7; j++) win[d][j] = win[d][j+1];
      win[d][fc[d]-1] = s;
    end
    // Y follows s once the last fc synced values all differ.
    ny = ye[d];
    for (int c = 0; c < 4; c++) begin
      diff = (wn[d] == fc[d]);
      for (int j = 0; j < 8; j++)
        if (j < fc[d] && win[d][j][c] == ye[d][c]) diff = 0;
      if (diff) ny[c] = s[c];
    end
    re[d] = ny & ~ye[d];
    fe[d] = ~ny & ye[d];
    ye[d] = ny;
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic check(input string nm,
                       input logic [3:0] act,
                       input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b @%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("y0",    {3'b000, y0}, ye[0]);
      check("rise0", {3'b000, r0}, re[0]);
      check("fall0", {3'b000, f0}, fe[0]);
      check("y1",    y1, ye[1]);
      check("rise1", r1, re[1]);
      check("fall1", f1, fe[1]);
      check("rf1_excl", r1 & f1, 4'b0000);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_in = 4'b1010;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #1;
    check("rst_y0", {3'b000, y0}, 4'b0000);
    check("rst_y1", y1, 4'b1010);
    check("rst_r1", r1, 4'b0000);
    started = 1'b1;
    #11 rstn = 1'b1;
    // Input equal to reset level across release: no activity.
    repeat (10) step();
    check("hold_y1", y1, 4'b1010);
    check("hold_r1", r1 | f1, 4'b0000);

    // Single rising edge: latency 3 (d0) and 6 (d1).
    a_in = 4'b1011;
    step();
    check("lat_k0", {3'b000, y0}, 4'b0000);
    step();
    check("lat_k1", {3'b000, y0}, 4'b0000);
    step();
    check("lat_k2_y", {3'b000, y0}, 4'b0001);
    check("lat_k2_r", {3'b000, r0}, 4'b0001);
    step();
    check("lat_k3_r", {3'b000, r0}, 4'b0000);
    step();
    check("lat_k4_y1", y1, 4'b1010);
    step();
    check("lat_k5_y1", y1, 4'b1011);
    check("lat_k5_r1", r1, 4'b0001);
    step();
    check("lat_k6_r1", r1, 4'b0000);

    // Two-cycle glitch on channel 2 is swallowed.
    a_in = 4'b1111;
    repeat (2) step();
    a_in = 4'b1011;
    repeat (10) step();
    check("glitch_y1", y1, 4'b1011);

    // Exactly three cycles commits, then falls back.
    a_in = 4'b1111;
    repeat (3) step();
    a_in = 4'b1011;
    repeat (2) step();
    check("pulse_k4", y1, 4'b1011);
    step();
    check("pulse_k5_y", y1, 4'b1111);
    check("pulse_k5_r", r1, 4'b0100);
    repeat (2) step();
    check("pulse_k7", y1, 4'b1111);
    step();
    check("pulse_k8_y", y1, 4'b1011);
    check("pulse_k8_f", f1, 4'b0100);
    repeat (4) step();

    // Reset while channel 2 is mid-count.
    a_in = 4'b1111;
    repeat (5) step();
    #2 rstn = 1'b0;
    #1;
    check("midrst_y1", y1, 4'b1010);
    check("midrst_y0", {3'b000, y0}, 4'b0000);
    check("midrst_rf", r1 | f1, 4'b0000);
    #3 rstn = 1'b1;
    #1;
    check("release_rf", r1 | f1, 4'b0000);
    repeat (2) step();
    check("rel_r2_y0", {3'b000, y0}, 4'b0000);
    step();
    check("rel_r3_y0", {3'b000, y0}, 4'b0001);
    repeat (2) step();
    check("rel_r5_y1", y1, 4'b1010);
    step();
    check("rel_r6_y1", y1, 4'b1111);
    check("rel_r6_r1", r1, 4'b0101);

    // Random pins changing between clock edges.
    for (int i = 0; i < 10000; i++) begin
      logic [7:0] r;
      @(posedge clk);
      #($urandom_range(1, 8));
      r = 8'($urandom);
      a_in = a_in ^ (r[3:0] & r[7:4]);
      if (i % 2500 == 1234) begin
        rstn = 1'b0;
        @(posedge clk);
        #4 rstn = 1'b1;
      end
    end
    repeat (3) step();
    started = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pin_synch_filter.md
Name: pin_synch_filter

Overview:
- Multi-channel successor to the two-stage pin synchronizer.
- Brings WIDTH asynchronous external pins into the clk domain through a STAGES-deep flop chain per channel.
- Per channel, a glitch/debounce filter follows the chain, then registered rise/fall pulse detection.
- Sits between top-level input pads (buttons, UART RX, JTAG-style lines) and core logic, replacing ad-hoc synchronizer-plus-debounce pairs.

Parameters:
- WIDTH, 1, number of independent channels.
- STAGES, 2, synchronizer depth; legal range 2..4, elaboration error outside it.
- FILTER_CYCLES, 1, consecutive synchronized cycles a new level must hold before Y changes; 1 = no filtering; legal range 1..65535.
- RST_VAL, 0 (WIDTH bits), per-channel reset level of sync flops and Y (e.g. 1 for idle-high UART RX).

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- A  input  WIDTH  asynchronous pin inputs.
- Y  output  WIDTH  synchronized, filtered level.
- rise  output  WIDTH  one-cycle pulse when Y goes 0->1.
- fall  output  WIDTH  one-cycle pulse when Y goes 1->0.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low: rstn low immediately forces all state, no clock needed.
- Reset state:
  - All sync flops and Y = RST_VAL.
  - Filter counters = 0.
  - rise = fall = 0.
- Channels are fully independent; no cross-channel state.
- Sync chain: S[0] <= A[i], S[j] <= S[j-1]. Synchronized value s = S[STAGES-1].
- Filter, per channel: counter cnt, width max(1, clog2(FILTER_CYCLES)).
  - s == Y: cnt <= 0 (any glitch shorter than the threshold is discarded, counting restarts).
  - s != Y and cnt < FILTER_CYCLES-1: cnt <= cnt+1, Y holds.
  - s != Y and cnt == FILTER_CYCLES-1: Y <= s, cnt <= 0.
  - FILTER_CYCLES=1: Y <= s every cycle; cnt is constant 0.
- Latency: A changes and stays stable before edge k. Y reflects it after edge k+STAGES+FILTER_CYCLES-1, i.e. STAGES+FILTER_CYCLES edges total. Defaults give 3 edges.
- Edge pulses are registered and assert in the same cycle Y shows the new value:
  - rise <= (Y_next & ~Y).
  - fall <= (~Y_next & Y).
  - Each lasts exactly one cycle. rise and fall are never both high on a channel.
- Toggling input: a pulse stable for fewer than FILTER_CYCLES synchronized cycles produces no Y change and no pulse. A pulse stable for exactly FILTER_CYCLES cycles produces one Y change.
- Counter saturation is impossible; cnt resets on the commit cycle.
- Reset mid-count: everything returns to the reset state immediately. No rise/fall is produced by reset itself, including on deassertion.
- First edges after rstn deasserts: if A != RST_VAL, normal latency applies and a pulse results.
- No combinational path from A to any output. All outputs are driven directly by flops.

Decomposition:
- Shared common package/header holds:
  - a clog2 helper function (the counter-width rule above);
  - STAGES_MIN=2 and STAGES_MAX=4 constants used for the elaboration check.
- One sub-module, pin_filter_chan: single channel holding chain, counter, Y, rise and fall. It takes STAGES, FILTER_CYCLES and RST_VAL (1 bit) as parameters.
- The top generates WIDTH instances and slices RST_VAL per channel.
- The existing DffSynch is reusable for chain flops only if its reset value is parametrisable; otherwise pin_filter_chan uses plain flops.

Test Plan:
1. Defaults (WIDTH=1, STAGES=2, FILTER=1, RST_VAL=0): A 0->1 before edge 10 -> Y=1 after edge 12; rise=1 for exactly the cycle after edge 12; fall stays 0.
2. WIDTH=4, STAGES=3, FILTER=4: A[2] high for 3 clocks then low -> Y stays 0000, no pulses. A[2] high for 4 clocks -> Y[2]=1 after edge k+6, rise[2] one cycle. A[2] low again -> Y[2]=0 after another 7 edges, one fall[2] pulse.
3. RST_VAL=4'b1010, A held 4'b1010 across reset release -> Y=1010 throughout, no rise/fall ever.
4. Reset mid-count (FILTER=8): A goes 1, rstn pulsed low after 5 counting cycles -> Y=RST_VAL immediately, cnt cleared. After release, full 2+8 edges elapse before Y=1.
5. Per-channel independence, WIDTH=8: A toggles 0x00->0xFF->0x0F on well-separated cycles -> exactly one rise and one fall on channels 7..4, one rise only on channels 3..0.
6. Random A with clock-asynchronous timing, 10k cycles, FILTER=3, against a reference model -> Y, rise and fall match every cycle. Y never changes on a run shorter than 3 synchronized cycles.
